pattern_sequencer: RTL and testbench

PATTERN_SEQUENCER -- requirements
Module: pattern_sequencer

---
 rtl/pattern_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_pattern_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_sequencer.sv
// rtl/pattern_sequencer.sv - time-shares one LED strand driver among several pattern sources
// Optional feature macro: PATTERN_SEQ_TIMEOUT_EN (answer black after TIMEOUT_CYCLES of WAIT)
module pattern_sequencer #(
   parameter int NUM_LEDS           = 20,
   parameter int NUM_PATTERNS       = 4,
   parameter int FRAMES_PER_PATTERN = 100,
   parameter int COLOR_WIDTH        = 8,
   parameter int TIMEOUT_CYCLES     = 64,
   localparam int LED_W             = $clog2(NUM_LEDS),
   localparam int PAT_W             = $clog2(NUM_PATTERNS)
) (
   input  logic                                clk_in,
   input  logic                                rst_in,
   input  logic [LED_W-1:0]                    next_led_request,
   input  logic                                request_valid,
   input  logic                                skip_in,
   output logic [LED_W-1:0]                    pat_request_out,
   output logic [NUM_PATTERNS-1:0]             pat_request_valid_out,
   input  logic [NUM_PATTERNS*COLOR_WIDTH-1:0] pat_green_in,
   input  logic [NUM_PATTERNS*COLOR_WIDTH-1:0] pat_red_in,
   input  logic [NUM_PATTERNS*COLOR_WIDTH-1:0] pat_blue_in,
   input  logic [NUM_PATTERNS-1:0]             pat_color_ready_in,
   output logic [COLOR_WIDTH-1:0]              green_out,
   output logic [COLOR_WIDTH-1:0]              red_out,
   output logic [COLOR_WIDTH-1:0]              blue_out,
   output logic                                color_ready,
   output logic [PAT_W-1:0]                    active_pattern_out,
   output logic                                frame_done_out,
   output logic                                overrun_out
);

   localparam int FC_W = (FRAMES_PER_PATTERN > 1) ? $clog2(FRAMES_PER_PATTERN) : 1;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_WAIT    = 2'd1,
      S_RESPOND = 2'd2
   } state_t;

   state_t            state;
   state_t            state_next;
   logic [LED_W-1:0]  cur_idx;
   logic [FC_W-1:0]   frame_cnt;
   logic              skip_pending;

   logic              in_range;
   logic              req_accept;
   logic              req_black;
   logic              take_color;
   logic              wait_timeout;
   logic              respond;
   logic              frame_end;
   logic              advance;
   logic              drop;

`ifdef PATTERN_SEQ_TIMEOUT_EN
   localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [TO_W-1:0]   to_cnt;
`endif

   assign in_range  = (32'(next_led_request) < NUM_LEDS);
   assign frame_end = respond && (cur_idx == LED_W'(NUM_LEDS - 1));
   assign advance   = frame_end &&
                      ((frame_cnt == FC_W'(FRAMES_PER_PATTERN - 1)) || skip_pending || skip_in);
   assign drop      = request_valid && (state != S_IDLE);

   // State register
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic and per-cycle datapath controls
   always_comb begin
      state_next   = state;
      req_accept   = 1'b0;
      req_black    = 1'b0;
      take_color   = 1'b0;
      wait_timeout = 1'b0;
      respond      = 1'b0;
      case (state)
         S_IDLE: begin
            if (request_valid) begin
               if (in_range) begin
                  req_accept = 1'b1;
                  state_next = S_WAIT;
               end else begin
                  req_black  = 1'b1;
                  state_next = S_RESPOND;
               end
            end
         end
         S_WAIT: begin
            if (pat_color_ready_in[active_pattern_out]) begin
               take_color = 1'b1;
               state_next = S_RESPOND;
            end
`ifdef PATTERN_SEQ_TIMEOUT_EN
            else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
               wait_timeout = 1'b1;
               state_next   = S_RESPOND;
            end
`endif
         end
         S_RESPOND: begin
            respond    = 1'b1;
            state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

`ifdef PATTERN_SEQ_TIMEOUT_EN
   // Counts cycles spent waiting for the active pattern; restarts on every entry to WAIT
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         to_cnt <= '0;
      end else if (state != S_WAIT) begin
         to_cnt <= '0;
      end else begin
         to_cnt <= to_cnt + 1'b1;
      end
   end
`endif

   // Request forwarding, color capture and response strobes
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         pat_request_out       <= '0;
         pat_request_valid_out <= '0;
         cur_idx               <= '0;
         green_out             <= '0;
         red_out               <= '0;
         blue_out              <= '0;
         color_ready           <= 1'b0;
         frame_done_out        <= 1'b0;
         overrun_out           <= 1'b0;
      end else begin
         pat_request_valid_out <= '0;
         color_ready           <= 1'b0;
         frame_done_out        <= 1'b0;
         if (req_accept) begin
            pat_request_out       <= next_led_request;
            pat_request_valid_out <= NUM_PATTERNS'(1) << active_pattern_out;
            cur_idx               <= next_led_request;
         end
         if (req_black) begin
            cur_idx   <= next_led_request;
            green_out <= '0;
            red_out   <= '0;
            blue_out  <= '0;
         end
         if (take_color) begin
            green_out <= pat_green_in[active_pattern_out*COLOR_WIDTH +: COLOR_WIDTH];
            red_out   <= pat_red_in[active_pattern_out*COLOR_WIDTH +: COLOR_WIDTH];
            blue_out  <= pat_blue_in[active_pattern_out*COLOR_WIDTH +: COLOR_WIDTH];
         end
         if (wait_timeout) begin
            green_out <= '0;
            red_out   <= '0;
            blue_out  <= '0;
         end
         if (respond) begin
            color_ready    <= 1'b1;
            frame_done_out <= frame_end;
         end
         if (drop) begin
            overrun_out <= 1'b1;
         end
      end
   end

   // Pattern rotation: frames counted per pattern, skips deferred to the frame end
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         active_pattern_out <= '0;
         frame_cnt          <= '0;
         skip_pending       <= 1'b0;
      end else begin
         if (skip_in) begin
            skip_pending <= 1'b1;
         end
         if (frame_end) begin
            if (advance) begin
               active_pattern_out <= (active_pattern_out == PAT_W'(NUM_PATTERNS - 1)) ?
                                     '0 : active_pattern_out + 1'b1;
               frame_cnt          <= '0;
               skip_pending       <= 1'b0;
            end else begin
               frame_cnt <= frame_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_pattern_sequencer.sv
// tb/tb_pattern_sequencer.sv - directed bench for pattern_sequencer (20 LEDs, 4 patterns, 2 frames/pattern)
module tb_pattern_sequencer;

   logic        clk_in = 1'b0;
   logic        rst_in = 1'b1;
   logic [4:0]  next_led_request = '0;
   logic        request_valid = 1'b0;
   logic        skip_in = 1'b0;
   logic [4:0]  pat_request_out;
   logic [3:0]  pat_request_valid_out;
   logic [31:0] pat_green_in = '0;
   logic [31:0] pat_red_in = '0;
   logic [31:0] pat_blue_in = '0;
   logic [3:0]  pat_color_ready_in = '0;
   logic [7:0]  green_out;
   logic [7:0]  red_out;
   logic [7:0]  blue_out;
   logic        color_ready;
   logic [1:0]  active_pattern_out;
   logic        frame_done_out;
   logic        overrun_out;

   int checks = 0;
   int errors = 0;

   pattern_sequencer #(
      .NUM_LEDS(20), .NUM_PATTERNS(4), .FRAMES_PER_PATTERN(2),
      .COLOR_WIDTH(8), .TIMEOUT_CYCLES(64)
   ) dut (
      .clk_in(clk_in), .rst_in(rst_in),
      .next_led_request(next_led_request), .request_valid(request_valid), .skip_in(skip_in),
      .pat_request_out(pat_request_out), .pat_request_valid_out(pat_request_valid_out),
      .pat_green_in(pat_green_in), .pat_red_in(pat_red_in), .pat_blue_in(pat_blue_in),
      .pat_color_ready_in(pat_color_ready_in),
      .green_out(green_out), .red_out(red_out), .blue_out(blue_out),
      .color_ready(color_ready), .active_pattern_out(active_pattern_out),
      .frame_done_out(frame_done_out), .overrun_out(overrun_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_green"}, green_out, 0);
      check({tag, "_red"}, red_out, 0);
      check({tag, "_blue"}, blue_out, 0);
      check({tag, "_cready"}, color_ready, 0);
      check({tag, "_preq"}, pat_request_out, 0);
      check({tag, "_pvalid"}, pat_request_valid_out, 0);
      check({tag, "_fdone"}, frame_done_out, 0);
      check({tag, "_overrun"}, overrun_out, 0);
      check({tag, "_active"}, active_pattern_out, 0);
   endtask

   // Active slice carries the wanted color; other slices carry its complement
   task automatic set_colors(input int pat, input logic [7:0] g, input logic [7:0] r, input logic [7:0] b);
      for (int k = 0; k < 4; k++) begin
         pat_green_in[k*8 +: 8] = (k == pat) ? g : ~g;
         pat_red_in[k*8 +: 8]   = (k == pat) ? r : ~r;
         pat_blue_in[k*8 +: 8]  = (k == pat) ? b : ~b;
      end
   endtask

   // One in-range request answered by pattern pat one cycle after the strobe.
   // skip_at: 0 none, 1 with the request, 2 during the RESPOND cycle.
   task automatic led_req(input logic [4:0] idx, input int pat, input logic [7:0] g,
                          input logic [7:0] r, input logic [7:0] b, input int skip_at);
      logic [3:0] exp_oh;
      exp_oh = 4'b0001 << pat;
      @(negedge clk_in);
      next_led_request = idx;
      request_valid    = 1'b1;
      skip_in          = (skip_at == 1);
      @(negedge clk_in);
      request_valid = 1'b0;
      skip_in       = 1'b0;
      check("strobe", pat_request_valid_out, exp_oh);
      check("req_idx", pat_request_out, idx);
      check("active_mid", active_pattern_out, pat);
      set_colors(pat, g, r, b);
      pat_color_ready_in = exp_oh;
      @(negedge clk_in);
      pat_color_ready_in = '0;
      check("strobe_clr", pat_request_valid_out, 0);
      check("early_cready", color_ready, 0);
      if (skip_at == 2) skip_in = 1'b1;
      @(negedge clk_in);
      skip_in = 1'b0;
      check("cready", color_ready, 1);
      check("green", green_out, g);
      check("red", red_out, r);
      check("blue", blue_out, b);
      check("fdone", frame_done_out, (idx == 5'd19));
   endtask

   task automatic run_frame(input int pat, input int skip_idx, input int skip_at, input int exp_after);
      for (int i = 0; i < 20; i++) begin
         led_req(5'(i), pat, 8'(i * 7), 8'(255 - i), 8'(i + pat * 16),
                 (i == skip_idx) ? skip_at : 0);
      end
      check("active_after_frame", active_pattern_out, exp_after);
   endtask

   initial begin
      int n;
      logic seen;

      // Reset values
      #2 rst_in = 1'b0;
      #1 check_all_zero("reset");
      repeat (2) @(negedge clk_in);
      rst_in = 1'b1;

      // idx 5, pattern 0 answers FF/00/80
      led_req(5'd5, 0, 8'hFF, 8'h00, 8'h80, 0);

      // Out-of-range idx 25: nothing forwarded, black after two cycles
      set_colors(0, 8'h12, 8'h34, 8'h56);
      pat_color_ready_in = 4'b1111;
      @(negedge clk_in);
      next_led_request = 5'd25;
      request_valid    = 1'b1;
      @(negedge clk_in);
      request_valid = 1'b0;
      check("oor_strobe", pat_request_valid_out, 0);
      check("oor_preq_held", pat_request_out, 5);
      check("oor_early", color_ready, 0);
      @(negedge clk_in);
      pat_color_ready_in = '0;
      check("oor_cready", color_ready, 1);
      check("oor_green", green_out, 0);
      check("oor_red", red_out, 0);
      check("oor_blue", blue_out, 0);
      check("oor_fdone", frame_done_out, 0);

      // Ready from non-active patterns is ignored
      @(negedge clk_in);
      next_led_request = 5'd3;
      request_valid    = 1'b1;
      @(negedge clk_in);
      request_valid = 1'b0;
      check("na_strobe", pat_request_valid_out, 4'b0001);
      set_colors(0, 8'h21, 8'h43, 8'h65);
      pat_color_ready_in = 4'b1110;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_in);
         check("na_ignored", color_ready, 0);
      end
      pat_color_ready_in = 4'b0001;
      @(negedge clk_in);
      pat_color_ready_in = '0;
      @(negedge clk_in);
      check("na_cready", color_ready, 1);
      check("na_green", green_out, 8'h21);
      check("na_blue", blue_out, 8'h65);

      // Four full frames at two frames per pattern: 0,0,1,1,2
      run_frame(0, -1, 0, 0);
      run_frame(0, -1, 0, 1);
      run_frame(1, -1, 0, 1);
      run_frame(1, -1, 0, 2);

      // Skip at idx 7: held until frame end, counter restarts, wrap 3 -> 0
      run_frame(2, 7, 1, 3);
      run_frame(3, -1, 0, 3);
      run_frame(3, -1, 0, 0);

      // Skip coincident with the frame end takes effect at that frame end
      run_frame(0, 19, 2, 1);

      // Request during WAIT is dropped and overrun sticks until reset
      check("ovr_before", overrun_out, 0);
      @(negedge clk_in);
      next_led_request = 5'd4;
      request_valid    = 1'b1;
      @(negedge clk_in);
      check("ovr_strobe", pat_request_valid_out, 4'b0010);
      next_led_request = 5'd6;
      @(negedge clk_in);
      request_valid = 1'b0;
      check("ovr_set", overrun_out, 1);
      check("ovr_no_fwd", pat_request_valid_out, 0);
      check("ovr_idx_kept", pat_request_out, 4);
      set_colors(1, 8'h5A, 8'hA5, 8'h3C);
      pat_color_ready_in = 4'b0010;
      @(negedge clk_in);
      pat_color_ready_in = '0;
      @(negedge clk_in);
      check("ovr_cready", color_ready, 1);
      check("ovr_green", green_out, 8'h5A);
      repeat (5) @(negedge clk_in);
      check("ovr_held", overrun_out, 1);
      rst_in = 1'b0;
      #1 check_all_zero("ovr_reset");
      @(negedge clk_in);
      rst_in = 1'b1;

      // Reset while in WAIT abandons the request
      @(negedge clk_in);
      next_led_request = 5'd2;
      request_valid    = 1'b1;
      @(negedge clk_in);
      request_valid = 1'b0;
      check("rw_strobe", pat_request_valid_out, 4'b0001);
      rst_in = 1'b0;
      #1 check("rw_strobe_clr", pat_request_valid_out, 0);
      @(negedge clk_in);
      rst_in = 1'b1;
      set_colors(0, 8'h77, 8'h88, 8'h99);
      pat_color_ready_in = 4'b0001;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_in);
         check("rw_no_cready", color_ready, 0);
      end
      pat_color_ready_in = '0;
      led_req(5'd8, 0, 8'h01, 8'h02, 8'h03, 0);

      // Pattern never answers
      @(negedge clk_in);
      next_led_request = 5'd9;
      request_valid    = 1'b1;
`ifdef PATTERN_SEQ_TIMEOUT_EN
      n = 0;
      for (int i = 1; i <= 200; i++) begin
         @(negedge clk_in);
         request_valid = 1'b0;
         if (color_ready === 1'b1 && n == 0) begin
            n = i;
            check("to_green", green_out, 0);
            check("to_red", red_out, 0);
            check("to_blue", blue_out, 0);
         end
      end
      check("to_latency", n, 66);
`else
      seen = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk_in);
         request_valid = 1'b0;
         if (color_ready !== 1'b0) seen = 1'b1;
      end
      check("no_to_cready", seen, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
